// File: rtl/mul_pkg.sv
// Shared defaults, ID-width helper and sequencer FSM states for the multiplier arbiter.
package mul_pkg;

   localparam int unsigned MulN    = 4;
   localparam int unsigned MulNreq = 4;
   localparam int unsigned MulLat  = 3;

   // Requester ID width; a single requester still needs a 1-bit tag field.
   function automatic int unsigned id_width(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StIdle
   } arb_state_e;

endpackage

// File: rtl/mul.sv
// Three-stage pipelined unsigned multiplier: operand register, product register, output register.
module mul #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [N-1:0]   a_q, b_q;
   logic [2*N-1:0] prod_q, p_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         p_q    <= '0;
      end else begin
         a_q    <= a;
         b_q    <= b;
         prod_q <= (2*N)'(a_q) * (2*N)'(b_q);
         p_q    <= prod_q;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ requesters, with an ID tag
// pipe to route products back and a drain control to empty the datapath.
module mul_arbiter
   import mul_pkg::*;
#(
   parameter int unsigned N    = MulN,
   parameter int unsigned NREQ = MulNreq,
   parameter int unsigned LAT  = MulLat
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*N-1:0]    rsp_p,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              busy
);

   localparam int unsigned IdW = id_width(NREQ);

   arb_state_e              state_q, state_d;
   logic [IdW-1:0]          ptr_q, ptr_d;
   logic [LAT-1:0]          tag_valid_q;
   logic [LAT-1:0][IdW-1:0] tag_id_q;

   logic [NREQ-1:0] grant;
   logic [IdW-1:0]  gnt_id;
   logic            gnt_any;
   logic            transfer;
   logic [N-1:0]    mul_a, mul_b;
   logic            mul_rst;

   // First valid requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      logic [IdW-1:0] idx;
      idx     = '0;
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IdW'((32'(ptr_q) + k) % NREQ);
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
      if (gnt_any) begin
         grant[gnt_id] = 1'b1;
      end
   end

   // Reset gates the grant so nothing can appear ready while the pipe is held clear.
   assign req_ready = (rst_n && (state_q == StRun)) ? grant : '0;
   assign transfer  = |req_ready;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            mul_a = req_a[i*N +: N];
            mul_b = req_b[i*N +: N];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (transfer) begin
         ptr_d = (gnt_id == IdW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign busy = |tag_valid_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (drain_req) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!drain_req) begin
               state_d = StRun;
            end else if (!busy) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (!drain_req) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // DRAIN and IDLE both block grants; drain_done tracks emptiness directly so it rises
   // the cycle after the last response rather than waiting for the IDLE transition.
   assign drain_done = drain_req && !busy && (state_q != StRun);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ptr_q       <= '0;
         tag_valid_q <= '0;
         tag_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         tag_valid_q <= {tag_valid_q[LAT-2:0], transfer};
         tag_id_q    <= {tag_id_q[LAT-2:0], gnt_id};
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tag_valid_q[LAT-1]) begin
         rsp_valid[tag_id_q[LAT-1]] = 1'b1;
      end
   end

   assign mul_rst = ~rst_n;

   mul #(
      .N(N)
   ) u_mul (
      .clk(clk),
      .rst(mul_rst),
      .a  (mul_a),
      .b  (mul_b),
      .p  (rsp_p)
   );

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of grants, response timing and drain status.
module tb_mul_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 3;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   rsp_valid;
   logic [2*N-1:0]    rsp_p;
   logic              drain_req;
   logic              drain_done;
   logic              busy;

   mul_arbiter #(
      .N   (N),
      .NREQ(NREQ),
      .LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_p     (rsp_p),
      .drain_req (drain_req),
      .drain_done(drain_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      int unsigned id;
      int unsigned p;
   } rsp_t;

   int          errors = 0;
   int          checks = 0;
   bit          pend[NREQ];
   int unsigned pa[NREQ];
   int unsigned pb[NREQ];
   int unsigned ptr;
   int unsigned edges;
   bit          en;
   bit          drain_lvl;
   rsp_t        q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, edges);
      end
   endtask

   task automatic post(input int i, input int unsigned a, input int unsigned b);
      pend[i] = 1'b1;
      pa[i]   = a;
      pb[i]   = b;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rv;
      int unsigned     gid;
      int unsigned     idx;
      bit              found;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]     = pend[i];
         req_a[i*N +: N]  = N'(pa[i]);
         req_b[i*N +: N]  = N'(pb[i]);
      end
      drain_req = drain_lvl;
      #1;
      found = 1'b0;
      gid   = 0;
      if (en) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (!found && pend[idx]) begin
               found = 1'b1;
               gid   = idx;
            end
         end
      end
      exp_rdy = found ? (NREQ'(1) << gid) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_rv = '0;
      if (q.size() != 0 && q[0].due == edges) exp_rv = NREQ'(1) << q[0].id;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) chk("rsp_p", 32'(rsp_p), q[0].p);
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("drain_done", 32'(drain_done), 32'(drain_lvl && !en && q.size() == 0));
      if (exp_rv != '0) void'(q.pop_front());
      @(posedge clk);
      edges++;
      if (found) begin
         q.push_back('{due: edges + LAT - 1, id: gid, p: pa[gid] * pb[gid]});
         ptr       = (gid + 1) % NREQ;
         pend[gid] = 1'b0;
      end
      en = !drain_lvl;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   // Asynchronous reset asserted mid-cycle, held across one rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_p", 32'(rsp_p), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drain_done", 32'(drain_done), 32'd0);
      q.delete();
      ptr = 0;
      en  = 1'b1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      @(posedge clk);
      edges++;
      #1;
      chk("rst_hold_rsp_p", 32'(rsp_p), 32'd0);
      chk("rst_hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      drain_req = 1'b0;
      drain_lvl = 1'b0;
      edges     = 0;
      ptr       = 0;
      en        = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0;
         pa[i]   = 0;
         pb[i]   = 0;
      end
      @(negedge clk);
      req_valid = '1;
      do_reset();

      // Single operation on requester 0.
      post(0, 3, 2);
      run(5);

      // All requesters continuously valid: strict rotation.
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) post(i, i + 1, 5);
         end
         tick();
      end
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      run(4);

      // Largest operands on the last requester.
      post(3, 15, 15);
      run(4);

      // Drain with three operations in flight; the third is granted as drain rises.
      post(0, 7, 9);
      post(1, 11, 13);
      post(2, 14, 6);
      run(2);
      drain_lvl = 1'b1;
      post(3, 4, 4);
      run(7);
      drain_lvl = 1'b0;
      run(4);

      // Reset with two operations in flight.
      post(0, 5, 5);
      post(1, 6, 6);
      run(2);
      do_reset();
      post(1, 9, 3);
      post(0, 8, 2);
      run(6);

      // Pointer fairness: park ptr at 2, then requesters 2 and 1 compete.
      post(1, 2, 2);
      tick();
      post(2, 12, 12);
      post(1, 13, 13);
      run(2);
      post(1, 1, 3);
      post(2, 3, 3);
      run(5);

      // Random traffic with occasional drains and one reset.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               post(i, $urandom_range(15, 0), $urandom_range(15, 0));
            end
         end
         if ($urandom_range(15, 0) == 0) drain_lvl = !drain_lvl;
         if (c == 200) do_reset();
         tick();
      end
      drain_lvl = 1'b1;
      run(8);
      drain_lvl = 1'b0;
      run(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined unsigned multiplier (`mul`, 3-stage: input register, product, output register) between NREQ requesters. It grants at most one request per cycle, tracks each operation's requester ID through the multiplier pipeline, and routes each product back to its requester. A drain control stops new grants and reports when the pipeline is empty, so software can reconfigure or gate the datapath.

## Interface
- N, 4, operand width in bits; product width is 2*N
- NREQ, 4, number of requesters (2..8)
- LAT, 3, multiplier latency in clock edges; must match the instantiated `mul`
- clk  input  1  system clock, all logic rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  per-requester operation request
- req_ready  output  NREQ  per-requester grant, one-hot or zero
- req_a  input  NREQ*N  packed multiplicands, requester i at [i*N +: N]
- req_b  input  NREQ*N  packed multipliers, same packing
- rsp_valid  output  NREQ  one-hot: product for requester i on rsp_p this cycle
- rsp_p  output  2*N  product, shared by all requesters
- drain_req  input  1  level; stop granting and empty the pipeline
- drain_done  output  1  high while drain_req=1 and pipeline empty
- busy  output  1  high when any operation is in flight

## Operation
- Handshake: transfer on requester i when req_valid[i] & req_ready[i] at a rising edge; req_ready is combinational from req_valid, rr pointer and FSM state; requester must hold valid/operands until transfer.
- Arbitration: round-robin starting at pointer ptr; first valid requester at or after ptr (mod NREQ) is granted; after a transfer ptr <= granted index + 1 (mod NREQ); no transfer leaves ptr unchanged.
- Granted operands muxed onto multiplier A/B; multiplier accepts one operation per cycle, no stalls, so a grant is issued every cycle a valid exists in RUN.
- Tag pipeline: LAT stages of {valid, id[$clog2(NREQ)-1:0]}; stage 0 loads {transfer, granted id} each edge, others shift.
- rsp_valid = one-hot decode of last tag stage when its valid is set, else 0; rsp_p = multiplier P unmodified. No response backpressure: requesters must accept rsp_valid in the cycle it is high.
- Arithmetic: unsigned, P = A*B, full 2*N bits, never truncated.
- FSM: RUN (grants enabled) -> DRAIN when drain_req=1; DRAIN: req_ready=0, tags keep shifting; DRAIN -> IDLE when all tag valids are 0; IDLE: req_ready=0, drain_done=1; IDLE -> RUN when drain_req=0; DRAIN -> RUN if drain_req drops before empty.
- busy = OR of all tag valids.
- Multiplier reset driven from ~rst_n.
- Reset (including mid-operation): all tags cleared, in-flight results discarded (no rsp_valid for them), ptr=0, FSM=RUN.

## Timing
- Reset values: req_ready=0 while rst_n=0, rsp_valid=0, rsp_p=0, busy=0, drain_done=0.
- Latency: transfer at edge E -> rsp_valid/rsp_p valid in the cycle following edge E+LAT-1 (for LAT=3: visible after the third edge counting E).
- Throughput: one operation per cycle, back-to-back across different or same requesters.
- drain_req sampled at edge; first cycle after the sampling edge has req_ready=0. Transfer in the same cycle drain_req rises still completes and is drained.
- drain_done rises the cycle after the last rsp_valid of the drained set; with empty pipeline, one cycle after drain_req rises.
- Simultaneous req_valid from all requesters: each granted exactly once every NREQ cycles.

## Structure
- Package `mul_pkg`: default N, LAT, ID width function/localparam, FSM state enum {RUN, DRAIN, IDLE}.
- One sub-module: existing `mul` instantiated unmodified; arbiter, tag pipe and FSM live in `mul_arbiter`.

## Test plan
- Single op: req 0 sends A=3,B=2 -> rsp_valid=4'b0001, rsp_p=6 exactly 3 edges later; busy high for 3 cycles.
- All four valid continuously with A=i+1,B=5 -> grant order 0,1,2,3,0...; responses 5,10,15,20 in same order, one per cycle.
- Max operands A=15,B=15 on req 3 -> rsp_p=225 (8'hE1), rsp_valid=4'b1000.
- Drain: 3 ops in flight, raise drain_req -> req_ready stays 0, 3 responses still delivered, drain_done asserts the next cycle; drop drain_req -> grants resume.
- Reset asserted with 2 ops in flight -> outputs 0 immediately, no rsp_valid after release, first grant goes to req 0.
- Pointer fairness: req 2 and req 1 valid, ptr=2 -> req 2 first, then req 1, ptr ends at 2.
